// File: rtl/fsm_ksa_shuffle.sv
// RC4 key-scheduling shuffle over a 256-byte S memory.
// S is assumed to hold S[k] = k already. The block walks i = 0..255, updates j from S[i]
// and the cyclic key byte, and then swaps S[i] and S[j] through a single-port memory with
// a one-cycle read latency. Each iteration takes exactly eight cycles.
module fsm_ksa_shuffle #(
    parameter int unsigned KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_LEN-1:0]   secret_key,
    input  logic [7:0]             rd_data,
    output logic [7:0]             mem_addr,
    output logic [7:0]             wr_data,
    output logic                   wr_en,
    output logic                   finish
);

    localparam int unsigned KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdI,
        StWaitI,
        StCalcJ,
        StRdJ,
        StWaitJ,
        StWrI,
        StWrJ,
        StNext,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [7:0]          si_q, si_d;
    logic [7:0]          sj_q, sj_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [7:0]          key_byte;

    // Select the current key byte; byte 0 is the most significant byte of secret_key.
    always_comb begin
        key_byte = 8'h00;
        for (int unsigned k = 0; k < KEY_LEN; k++) begin
            if (kidx_q == KIDX_W'(k)) begin
                key_byte = secret_key[8*(KEY_LEN-1-k) +: 8];
            end
        end
    end

    // State and datapath registers; reset has priority over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;

        unique case (state_q)
            StIdle: begin
                i_d    = 8'h00;
                j_d    = 8'h00;
                kidx_d = '0;
                if (start) begin
                    state_d = StRdI;
                end
            end
            StRdI: begin
                state_d = StWaitI;
            end
            StWaitI: begin
                si_d    = rd_data;
                state_d = StCalcJ;
            end
            StCalcJ: begin
                // 8-bit add wraps j modulo 256.
                j_d     = j_q + si_q + key_byte;
                state_d = StRdJ;
            end
            StRdJ: begin
                state_d = StWaitJ;
            end
            StWaitJ: begin
                sj_d    = rd_data;
                state_d = StWrI;
            end
            StWrI: begin
                state_d = StWrJ;
            end
            StWrJ: begin
                state_d = StNext;
            end
            StNext: begin
                if (i_q == 8'hFF) begin
                    // i stays at 255; IDLE clears it before the next run.
                    state_d = StDone;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_W'(KEY_LEN - 1)) ? '0 : kidx_q + KIDX_W'(1);
                    state_d = StRdI;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Memory-side outputs decoded from the current state only.
    always_comb begin
        mem_addr = 8'h00;
        wr_data  = 8'h00;
        wr_en    = 1'b0;
        finish   = 1'b0;

        unique case (state_q)
            StRdI: begin
                mem_addr = i_q;
            end
            StRdJ: begin
                mem_addr = j_q;
            end
            StWrI: begin
                mem_addr = i_q;
                wr_data  = sj_q;
                wr_en    = 1'b1;
            end
            StWrJ: begin
                // When i == j this rewrites the same value to the same address.
                mem_addr = j_q;
                wr_data  = si_q;
                wr_en    = 1'b1;
            end
            StDone: begin
                finish = 1'b1;
            end
            default: begin
                mem_addr = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_ksa_shuffle.sv
// Scoreboard bench for fsm_ksa_shuffle: the stimulus side pushes expected writes and
// finish cycles, and a negedge monitor pops and compares them as the DUT produces them.
module tb_fsm_ksa_shuffle;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] secret_key = 24'h0;
    logic [7:0]  rd_data;
    logic [7:0]  mem_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        finish;

    logic [7:0]  mem [256];
    logic [7:0]  model_s [256];
    logic        init_req = 1'b0;
    logic        mon_en = 1'b0;

    wr_t         exp_wr [$];
    int          exp_fin [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          wtotal = 0;
    int          wprev = 0;
    logic [7:0]  wlog_addr [8192];
    logic [7:0]  wlog_data [8192];

    fsm_ksa_shuffle #(.KEY_LEN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .secret_key (secret_key),
        .rd_data    (rd_data),
        .mem_addr   (mem_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // S memory with one-cycle read latency.
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wr_en) begin
            mem[mem_addr] <= wr_data;
        end
        rd_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each write and each finish pulse against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en === 1'b1) begin
                wlog_addr[wtotal % 8192] = mem_addr;
                wlog_data[wtotal % 8192] = wr_data;
                wtotal++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                end
            end
            if (finish === 1'b1) begin
                if (exp_fin.size() == 0) begin
                    chk("unexpected_finish", 1, 0);
                end else begin
                    chk("finish_cycle", cyc, exp_fin.pop_front());
                    chk("writes_per_run", wtotal - wprev, 512);
                end
                wprev = wtotal;
            end
            if (rst === 1'b1) wprev = wtotal;
        end
    end

    // Software RC4 KSA on an identity S; queues the expected write stream.
    task automatic push_run(input logic [23:0] key, input int n_iter);
        logic [7:0] s [256];
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        int         idx;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        j = 8'h00;
        for (int i = 0; i < n_iter; i++) begin
            idx = 23 - 8 * (i % 3);
            kb  = key[idx -: 8];
            j   = j + s[i] + kb;
            exp_wr.push_back(wr_t'{addr: 8'(i), data: s[j]});
            exp_wr.push_back(wr_t'{addr: j, data: s[i]});
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int k = 0; k < 256; k++) model_s[k] = s[k];
    endtask

    task automatic init_mem();
        @(posedge clk); #1;
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
    endtask

    // Pulse start for one cycle; returns the accept cycle and write-log index.
    task automatic launch(input logic [23:0] key, input int n_iter, input bit expect_fin,
                          output int c, output int w0);
        secret_key = key;
        push_run(key, n_iter);
        @(posedge clk); #1;
        start = 1'b1;
        c     = cyc;
        w0    = wtotal;
        if (expect_fin) exp_fin.push_back(c + 2049);
        @(posedge clk); #1;
        start = 1'b0;
        chk("rd_i_first_addr", mem_addr, 0);
        chk("rd_i_first_wr_en", wr_en, 0);
    endtask

    task automatic wait_fin(input int c, input bit toggle);
        int n;
        n = 0;
        while (exp_fin.size() != 0 && n < 2300) begin
            @(posedge clk); #1;
            n++;
            start = toggle && (cyc == c + 100 || cyc == c + 1000 || cyc == c + 2040);
        end
        start = 1'b0;
        if (exp_fin.size() != 0) begin
            chk("finish_timeout", 0, 1);
            exp_fin.delete();
            exp_wr.delete();
        end
        repeat (4) @(posedge clk);
        #1;
        chk("writes_drained", exp_wr.size(), 0);
    endtask

    task automatic check_mem();
        for (int k = 0; k < 256; k++) chk("final_s", mem[k], model_s[k]);
    endtask

    initial begin
        int c;
        int w0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_finish", finish, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Key 030000: j = 3 on the first iteration.
        init_mem();
        launch(24'h030000, 256, 1'b1, c, w0);
        wait_fin(c, 1'b0);
        chk("k030000_wr0_addr", wlog_addr[w0], 0);
        chk("k030000_wr0_data", wlog_data[w0], 3);
        chk("k030000_wr1_addr", wlog_addr[w0 + 1], 3);
        chk("k030000_wr1_data", wlog_data[w0 + 1], 0);
        check_mem();

        // Key 000000: i == j == 0 on the first iteration, both writes to address 0.
        init_mem();
        launch(24'h000000, 256, 1'b1, c, w0);
        wait_fin(c, 1'b0);
        chk("k0_wr0_addr", wlog_addr[w0], 0);
        chk("k0_wr0_data", wlog_data[w0], 0);
        chk("k0_wr1_addr", wlog_addr[w0 + 1], 0);
        chk("k0_wr1_data", wlog_data[w0 + 1], 0);
        check_mem();

        // Key 00033C with start toggled mid-run; i=1 gives j = 0 + 1 + 3 = 4.
        init_mem();
        launch(24'h00033C, 256, 1'b1, c, w0);
        wait_fin(c, 1'b1);
        chk("k33c_wr2_addr", wlog_addr[w0 + 2], 1);
        chk("k33c_wr2_data", wlog_data[w0 + 2], 4);
        chk("k33c_wr3_addr", wlog_addr[w0 + 3], 4);
        chk("k33c_wr3_data", wlog_data[w0 + 3], 1);
        check_mem();

        // Reset while iteration i=100 is reading S[i].
        init_mem();
        launch(24'h00033C, 100, 1'b0, c, w0);
        do begin
            @(posedge clk); #1;
        end while (cyc < c + 801);
        chk("rd_i_100_addr", mem_addr, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_finish", finish, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_writes_drained", exp_wr.size(), 0);
        chk("abort_write_count", wtotal - w0, 200);

        // Restart from i=0 after the abort.
        init_mem();
        launch(24'h030000, 256, 1'b1, c, w0);
        wait_fin(c, 1'b0);
        chk("restart_wr0_addr", wlog_addr[w0], 0);
        chk("restart_wr0_data", wlog_data[w0], 3);
        check_mem();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_ksa_shuffle.md
FSM_KSA_SHUFFLE -- requirements
Module: fsm_ksa_shuffle

Interface
REQ-001 Parameter: KEY_LEN, default 3, number of secret key bytes used cyclically.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin shuffle; sampled only in IDLE.
REQ-006 secret_key  input  8*KEY_LEN  key bytes; byte 0 is the most significant byte (secret_key[8*KEY_LEN-1 -: 8]).
REQ-007 rd_data  input  8  S-memory read data, valid in the cycle after mem_addr is driven with wr_en low.
REQ-008 mem_addr  output  8  S-memory address.
REQ-009 wr_data  output  8  S-memory write data.
REQ-010 wr_en  output  1  S-memory write enable, one write per high cycle.
REQ-011 finish  output  1  one-cycle pulse on completion.

Function
REQ-012 The block SHALL run the RC4 key-scheduling swap on the 256-byte S memory: for i = 0..255, j = j + S[i] + key[i mod KEY_LEN] (mod 256), then swap S[i] and S[j].
REQ-013 The block SHALL treat the S memory as already initialized to S[k]=k by the upstream init stage; it SHALL NOT initialize S itself.
REQ-014 States SHALL be IDLE, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J, NEXT, DONE.
REQ-015 IDLE: i=0, j=0, key index=0; start=1 -> RD_I, otherwise stay in IDLE.
REQ-016 RD_I: mem_addr=i, wr_en=0 -> WAIT_I.
REQ-017 WAIT_I: latch si=rd_data -> CALC_J.
REQ-018 CALC_J: j <= j + si + key[key index], truncated to 8 bits -> RD_J.
REQ-019 RD_J: mem_addr=j (the new value), wr_en=0 -> WAIT_J.
REQ-020 WAIT_J: latch sj=rd_data -> WR_I.
REQ-021 WR_I: mem_addr=i, wr_data=sj, wr_en=1 -> WR_J.
REQ-022 WR_J: mem_addr=j, wr_data=si, wr_en=1 -> NEXT.
REQ-023 NEXT: if i==255 -> DONE; otherwise i increments, key index increments and wraps from KEY_LEN-1 to 0, -> RD_I.
REQ-024 DONE: finish=1 for exactly one cycle -> IDLE.
REQ-025 Each iteration SHALL take exactly 8 cycles; finish SHALL be high in cycle C+2049 when start is accepted in cycle C.
REQ-026 When i==j, the block SHALL perform both writes (same address, same value); S is left unchanged.
REQ-027 The i counter SHALL NOT wrap past 255; j SHALL wrap modulo 256.
REQ-028 start SHALL be ignored outside IDLE; start held high through DONE SHALL launch a new run from the following IDLE cycle.
REQ-029 secret_key SHALL be held stable by the user during a run; the block SHALL NOT register it.
REQ-030 wr_en SHALL be 0 in every state other than WR_I and WR_J; mem_addr and wr_data SHALL be 0 in IDLE and DONE.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE with i=0, j=0, si=0, sj=0, key index=0, wr_en=0, finish=0, mem_addr=0, wr_data=0.
REQ-032 rst SHALL have priority over start and over every state transition.
REQ-033 A reset mid-run SHALL abort the run with no further writes; S contents are not restored, and the next start SHALL begin again at i=0.

Verification
REQ-034 The bench SHALL cover: memory pre-loaded S[k]=k, secret_key=24'h030000, start pulse -> first writes are addr 0 data 3 (WR_I), then addr 3 data 0 (WR_J).
REQ-035 The bench SHALL cover: secret_key=24'h000000 -> i=0, j=0, and both writes go to addr 0 with data 0.
REQ-036 The bench SHALL cover: start accepted in cycle C -> finish high only in cycle C+2049, for exactly 1 cycle, with 512 wr_en cycles in total.
REQ-037 The bench SHALL cover: a full run with secret_key=24'h00033C -> final S matches a software RC4 KSA model byte-for-byte.
REQ-038 The bench SHALL cover: rst asserted at iteration i=100 -> the next cycle is IDLE with all outputs 0 and no write; a subsequent start restarts at mem_addr=0.
REQ-039 The bench SHALL cover: start toggled during a run -> no restart, and finish still arrives at C+2049.
